// File: rtl/disp_scan_ctrl.sv
// Frame-driven display controller: digit register bank, multi-cycle CLEAR and PWM digit scanning.
// Define DISP_FRAME_CHECK_EN to reject frames with nonzero reserved bits and flag o_frame_err.
module disp_scan_ctrl #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 250
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_frame_valid,
   input  logic [10:0]           i_frame_data,
   output logic                  o_frame_ready,
   output logic [3:0]            o_seg_data,
   output logic [NUM_DIGITS-1:0] o_digit_en,
   output logic                  o_frame_err
);

   localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);
   localparam logic [1:0] CmdWrite  = 2'b00;
   localparam logic [1:0] CmdBlank  = 2'b01;
   localparam logic [1:0] CmdBright = 2'b10;
   localparam logic [1:0] CmdClear  = 2'b11;
   localparam logic [3:0] DutyRst   = 4'd8;

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e                r_state, w_state_d;
   logic [IdxW-1:0]       r_clr_cnt, w_clr_cnt_d;
   logic [3:0]            r_digit   [NUM_DIGITS];
   logic [3:0]            w_digit_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_blank, w_blank_d;
   logic [3:0]            r_duty, w_duty_d;
   logic [PreW-1:0]       r_pre, w_pre_d;
   logic [3:0]            r_phase, w_phase_d;
   logic [IdxW-1:0]       r_idx, w_idx_d, w_idx_nxt;
   logic [3:0]            r_seg, w_seg_d;

   logic       w_accept;
   logic       w_exec;
   logic [1:0] w_cmd;
   logic [1:0] w_addr;
   logic [3:0] w_value;
   logic       w_pre_wrap;
   logic       w_slot_end;
   logic       w_lit;

   assign w_cmd         = i_frame_data[10:9];
   assign w_addr        = i_frame_data[8:7];
   assign w_value       = i_frame_data[3:0];
   assign o_frame_ready = (r_state == StIdle);
   assign w_accept      = i_frame_valid && o_frame_ready;
   assign o_seg_data    = r_seg;

`ifdef DISP_FRAME_CHECK_EN
   logic r_frame_err;
   logic w_rsvd_bad;

   assign w_rsvd_bad  = |i_frame_data[6:4];
   // Bad frames still complete the handshake so upstream never stalls on them.
   assign w_exec      = w_accept && !w_rsvd_bad;
   assign o_frame_err = r_frame_err;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_frame_err <= 1'b0;
      end else if (w_accept && w_rsvd_bad) begin
         r_frame_err <= 1'b1;
      end
   end
`else
   logic w_unused_rsvd;

   assign w_unused_rsvd = ^i_frame_data[6:4];
   assign w_exec        = w_accept;
   assign o_frame_err   = 1'b0;
`endif

   // Scan counters: pre -> phase -> digit slot.
   always_comb begin
      w_pre_wrap = (r_pre == PreMax);
      w_slot_end = w_pre_wrap && (r_phase == 4'hF);
      w_idx_nxt  = (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
      w_pre_d    = r_pre + 1'b1;
      w_phase_d  = r_phase;
      w_idx_d    = r_idx;
      w_seg_d    = r_seg;
      if (w_pre_wrap) begin
         w_pre_d   = '0;
         w_phase_d = r_phase + 4'd1;
      end
      if (w_slot_end) begin
         w_idx_d = w_idx_nxt;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IdxW'(i)) begin
               w_seg_d = r_digit[i];
            end
         end
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_clr_cnt_d = r_clr_cnt;
      case (r_state)
         StIdle: begin
            if (w_exec && (w_cmd == CmdClear)) begin
               w_state_d   = StClear;
               w_clr_cnt_d = '0;
            end
         end
         StClear: begin
            w_clr_cnt_d = r_clr_cnt + 1'b1;
            if (r_clr_cnt == IdxMax) begin
               w_state_d   = StIdle;
               w_clr_cnt_d = '0;
            end
         end
         default: begin
            w_state_d   = StIdle;
            w_clr_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      w_blank_d = r_blank;
      w_duty_d  = r_duty;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_digit_d[i] = r_digit[i];
      end
      if (r_state == StClear) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_clr_cnt == IdxW'(i)) begin
               w_digit_d[i] = '0;
            end
         end
         if (r_clr_cnt == '0) begin
            w_blank_d = '0;
            w_duty_d  = DutyRst;
         end
      end else if (w_exec) begin
         case (w_cmd)
            CmdWrite: begin
               // Addresses at or above NUM_DIGITS match no slot and are dropped.
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (int'(w_addr) == i) begin
                     w_digit_d[i] = w_value;
                  end
               end
            end
            CmdBlank:  w_blank_d = w_value[NUM_DIGITS-1:0];
            CmdBright: w_duty_d  = w_value;
            default:   ;
         endcase
      end
   end

   // Phase 0 stays dark so the seg_data change at a slot boundary never shows.
   always_comb begin
      w_lit      = (r_phase != 4'd0) && (r_phase <= r_duty);
      o_digit_en = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         o_digit_en[i] = w_lit && (r_idx == IdxW'(i)) && !r_blank[i];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= StIdle;
         r_clr_cnt <= '0;
         r_blank   <= '0;
         r_duty    <= DutyRst;
         r_pre     <= '0;
         r_phase   <= '0;
         r_idx     <= '0;
         r_seg     <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_digit[i] <= '0;
         end
      end else begin
         r_state   <= w_state_d;
         r_clr_cnt <= w_clr_cnt_d;
         r_blank   <= w_blank_d;
         r_duty    <= w_duty_d;
         r_pre     <= w_pre_d;
         r_phase   <= w_phase_d;
         r_idx     <= w_idx_d;
         r_seg     <= w_seg_d;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_digit[i] <= w_digit_d[i];
         end
      end
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: per-cycle scoreboard of expected outputs plus directed timing checks.
// Honours DISP_FRAME_CHECK_EN when it is defined for the whole build.
module tb_disp_scan_ctrl;

   localparam int ND   = 4;
   localparam int SDIV = 2;

   logic          clk;
   logic          rst_n;
   logic          frame_valid;
   logic [10:0]   frame_data;
   logic          frame_ready;
   logic [3:0]    seg_data;
   logic [ND-1:0] digit_en;
   logic          frame_err;

   typedef struct packed {
      logic [3:0]    seg;
      logic [ND-1:0] en;
      logic          ready;
      logic          err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Spec-level reference state
   int         cyc;
   int         m_pre, m_phase, m_idx, m_ccnt;
   logic [3:0] m_digit [ND];
   logic [3:0] m_blank, m_duty, m_seg;
   logic       m_clr, m_err;

`ifdef DISP_FRAME_CHECK_EN
   localparam logic       ExpErr = 1'b1;
   localparam logic [3:0] ExpD3  = 4'd0;
`else
   localparam logic       ExpErr = 1'b0;
   localparam logic [3:0] ExpD3  = 4'd7;
`endif

   disp_scan_ctrl #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SDIV)
   ) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_frame_valid (frame_valid),
      .i_frame_data  (frame_data),
      .o_frame_ready (frame_ready),
      .o_seg_data    (seg_data),
      .o_digit_en    (digit_en),
      .o_frame_err   (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic       acc, ok;
      logic [1:0] cmd, addr;
      logic [3:0] val;
      exp_t       e;
      if (!rst_n) begin
         cyc = 0; m_pre = 0; m_phase = 0; m_idx = 0; m_ccnt = 0;
         m_blank = 4'd0; m_duty = 4'd8; m_seg = 4'd0; m_clr = 1'b0; m_err = 1'b0;
         for (int i = 0; i < ND; i++) m_digit[i] = 4'd0;
      end else begin
         cyc++;
         acc  = frame_valid && !m_clr;
         cmd  = frame_data[10:9];
         addr = frame_data[8:7];
         val  = frame_data[3:0];
`ifdef DISP_FRAME_CHECK_EN
         ok = (frame_data[6:4] == 3'd0);
         if (acc && !ok) m_err = 1'b1;
`else
         ok = 1'b1;
`endif
         if (m_pre == SDIV - 1) begin
            m_pre = 0;
            if (m_phase == 15) begin
               m_phase = 0;
               m_idx   = (m_idx + 1) % ND;
               m_seg   = m_digit[m_idx];
            end else begin
               m_phase++;
            end
         end else begin
            m_pre++;
         end
         if (m_clr) begin
            m_digit[m_ccnt] = 4'd0;
            if (m_ccnt == 0) begin
               m_blank = 4'd0;
               m_duty  = 4'd8;
            end
            if (m_ccnt == ND - 1) m_clr = 1'b0;
            else m_ccnt++;
         end
         if (acc && ok) begin
            case (cmd)
               2'd0: m_digit[addr] = val;
               2'd1: m_blank = val;
               2'd2: m_duty = val;
               default: begin
                  m_clr  = 1'b1;
                  m_ccnt = 0;
               end
            endcase
         end
      end
      e.en = '0;
      if (m_phase >= 1 && m_phase <= int'(m_duty) && !m_blank[m_idx]) e.en = ND'(1 << m_idx);
      e.seg   = m_seg;
      e.ready = !m_clr;
      e.err   = m_err;
      sb_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq("sb_seg", 32'(seg_data), 32'(e.seg));
         check_eq("sb_en", 32'(digit_en), 32'(e.en));
         check_eq("sb_ready", 32'(frame_ready), 32'(e.ready));
         check_eq("sb_err", 32'(frame_err), 32'(e.err));
      end
   end

   task automatic wait_cyc(input int n);
      int guard;
      guard = 0;
      while (cyc < n && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < n) check_eq("wait_cyc_timeout", 32'(cyc), 32'(n));
   endtask

   task automatic send_frame(input logic [10:0] f);
      frame_valid = 1'b1;
      frame_data  = f;
      @(negedge clk);
      frame_valid = 1'b0;
      frame_data  = '0;
   endtask

   task automatic count_on(input int base, output int on, output logic [3:0] orv);
      wait_cyc(base);
      on  = 0;
      orv = '0;
      for (int k = 0; k < 128; k++) begin
         if (digit_en != '0) on++;
         orv |= digit_en;
         if (cyc == base + 32 && base == 1024) check_eq("clr_seg_d1", 32'(seg_data), 32'hA);
         if (cyc == base + 64 && base == 1024) check_eq("clr_seg_d2", 32'(seg_data), 32'h0);
         @(negedge clk);
      end
   endtask

   initial begin
      int         on;
      logic [3:0] orv;
      rst_n       = 1'b0;
      frame_valid = 1'b0;
      frame_data  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      check_eq("rst_seg", 32'(seg_data), 32'h0);
      check_eq("rst_en", 32'(digit_en), 32'h0);
      check_eq("rst_ready", 32'(frame_ready), 32'h1);
      check_eq("rst_err", 32'(frame_err), 32'h0);
      wait_cyc(1);  check_eq("en_c1", 32'(digit_en), 32'h0);
      wait_cyc(2);  check_eq("en_c2", 32'(digit_en), 32'h1);
      wait_cyc(17); check_eq("en_c17", 32'(digit_en), 32'h1);
      wait_cyc(18); check_eq("en_c18", 32'(digit_en), 32'h0);
      wait_cyc(34); check_eq("en_idx1", 32'(digit_en), 32'h2);

      wait_cyc(40); send_frame(11'b00_10_000_0101);
      wait_cyc(64); check_eq("wr_seg", 32'(seg_data), 32'h5);
      check_eq("wr_en_ph0", 32'(digit_en), 32'h0);
      wait_cyc(66); check_eq("wr_en_ph1", 32'(digit_en), 32'h4);
      wait_cyc(81); check_eq("wr_en_ph8", 32'(digit_en), 32'h4);
      wait_cyc(82); check_eq("wr_en_ph9", 32'(digit_en), 32'h0);

      wait_cyc(130); send_frame(11'b10_00_000_0000);
      count_on(256, on, orv);
      check_eq("bright0_on", 32'(on), 32'd0);
      wait_cyc(384); send_frame(11'b10_00_000_1111);
      count_on(512, on, orv);
      check_eq("bright15_on", 32'(on), 32'd120);

      wait_cyc(640); send_frame(11'b01_00_000_1010);
      count_on(768, on, orv);
      check_eq("blank_or", 32'(orv), 32'h5);

      // Fill digits, then CLEAR with a WRITE held behind it.
      wait_cyc(896);
      send_frame(11'b00_00_000_0001);
      send_frame(11'b00_01_000_0010);
      send_frame(11'b00_11_000_0011);
      frame_valid = 1'b1;
      frame_data  = 11'b11_00_000_0000;
      @(negedge clk);
      frame_data = 11'b00_01_000_1010;
      check_eq("clr_rdy0", 32'(frame_ready), 32'h0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check_eq("clr_rdy_lo", 32'(frame_ready), 32'h0);
      end
      @(negedge clk);
      check_eq("clr_rdy_back", 32'(frame_ready), 32'h1);
      @(negedge clk);
      frame_valid = 1'b0;
      frame_data  = '0;
      count_on(1024, on, orv);
      check_eq("clr_duty8_on", 32'(on), 32'd64);
      check_eq("clr_blank_or", 32'(orv), 32'hF);

      // CLEAR aborted by reset on its second cycle.
      wait_cyc(1200);
      send_frame(11'b10_00_000_0011);
      send_frame(11'b01_00_000_0001);
      send_frame(11'b00_10_000_1001);
      frame_valid = 1'b1;
      frame_data  = 11'b11_00_000_0000;
      @(negedge clk);
      frame_valid = 1'b0;
      frame_data  = '0;
      check_eq("abort_rdy0", 32'(frame_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("abort_rdy", 32'(frame_ready), 32'h1);
      check_eq("abort_en", 32'(digit_en), 32'h0);
      check_eq("abort_seg", 32'(seg_data), 32'h0);
      wait_cyc(2);  check_eq("abort_blank", 32'(digit_en), 32'h1);
      wait_cyc(17); check_eq("abort_duty", 32'(digit_en), 32'h1);

      // Reserved-bit frame followed by a valid one.
      wait_cyc(20); send_frame(11'b00_11_001_0111);
      wait_cyc(22); send_frame(11'b10_00_000_1000);
      wait_cyc(24); check_eq("rsvd_err", 32'(frame_err), 32'(ExpErr));
      wait_cyc(96); check_eq("rsvd_d3", 32'(seg_data), 32'(ExpD3));
      check_eq("rsvd_err_sticky", 32'(frame_err), 32'(ExpErr));

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Display controller between the SPI frame receiver and the seven-segment decoder. It accepts 11-bit command frames and holds a small digit register bank. It time-multiplexes the single `sevSegDisp` decoder across up to four digits with per-digit blanking and a 16-level brightness duty. A CLEAR command is sequenced over several cycles, with back-pressure on the frame input while it runs.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 1..4; write addresses at or above `NUM_DIGITS` are dropped.
- `SCAN_DIV`, 250: clk cycles per PWM phase, at least 1; one digit slot is 16*`SCAN_DIV` cycles.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `frame_valid`  in  1  frame available, already synchronised to `clk`.
- `frame_data`  in  11  frame: [10:9] cmd, [8:7] digit addr, [6:4] reserved, [3:0] value.
- `frame_ready`  out  1  block can accept a frame this cycle.
- `seg_data`  out  4  nibble to `sevSegDisp` `inWord`.
- `digit_en`  out  `NUM_DIGITS`  one-hot-or-zero digit enable, active high.
- `frame_err`  out  1  sticky reserved-bit error (see Configuration).

## Operation
- Handshake: a frame is consumed on a posedge where `frame_valid && frame_ready`. While `frame_ready` is low, upstream holds the frame and nothing is consumed.
- cmd 00 WRITE: `digit[addr] <= value`.
- cmd 01 BLANK: `blank_mask <= value[NUM_DIGITS-1:0]`; bit i=1 suppresses digit i.
- cmd 10 BRIGHT: `duty <= value`.
- cmd 11 CLEAR: runs a 2-state FSM, IDLE -> CLEAR -> IDLE.
  - Enter CLEAR the cycle after accept.
  - Clear one digit per cycle, index 0..`NUM_DIGITS`-1, writing 0.
  - `blank_mask` <= 0 and `duty` <= 8 on the first CLEAR cycle.
  - Return to IDLE after digit `NUM_DIGITS`-1 is cleared.
- `frame_ready` = 1 in IDLE, 0 in CLEAR.
- Scan counters:
  - `pre` counts 0..`SCAN_DIV`-1.
  - `phase` (4 bit) increments when `pre` wraps.
  - When `phase` wraps 15->0, `idx` advances modulo `NUM_DIGITS`.
- Scanning runs continuously, including during CLEAR.
- `seg_data` is loaded from `digit[next idx]` only at the slot boundary. A write to the digit currently shown becomes visible on its next slot.
- `digit_en[idx]` = 1 iff 1 <= `phase` <= `duty` and `blank_mask[idx]`==0.
  - `duty`=0 gives dark.
  - `duty`=15 gives 15/16 on-time.
  - Phase 0 is always off (anti-ghost gap covering the `seg_data` change).
- Reset values:
  - Registers: `digit[*]`=0, `blank_mask`=0, `duty`=8, `idx`=0, `phase`=0, `pre`=0, FSM=IDLE.
  - Outputs: `seg_data`=0, `digit_en`=0, `frame_ready`=1, `frame_err`=0.

## Timing
- Register update: one cycle after accept; WRITE/BLANK/BRIGHT are fully pipelined, back-to-back accepts allowed.
- CLEAR: `frame_ready` low for exactly `NUM_DIGITS` cycles starting the cycle after accept; a frame presented then is accepted on the first cycle `frame_ready` returns.
- Scan wrap: the first slot after reset shows digit 0. Slot k begins at cycle 16*`SCAN_DIV`*k; `digit_en` first rises at cycle `SCAN_DIV` after reset release.
- BLANK/BRIGHT mid-slot: take effect on the next posedge after update, not deferred to the slot boundary.
- Reset priority: `rst_n` low mid-CLEAR aborts it; all state returns to reset values on that edge.
- Width: `phase` <= `duty` is a 4-bit unsigned compare; `pre` is sized `$clog2(SCAN_DIV)` with a minimum of 1.

## Configuration
- `DISP_FRAME_CHECK_EN` defined:
  - A frame with nonzero [6:4] is still handshaken but its command is discarded.
  - `frame_err` sets on that accept and clears only on reset.
- `DISP_FRAME_CHECK_EN` undefined: [6:4] is ignored, every frame executes, and `frame_err` is tied 0.

## Test plan
All scenarios use `SCAN_DIV`=2, `NUM_DIGITS`=4.
- Reset release -> `seg_data`=0, `digit_en`=0, `frame_ready`=1; `digit_en`=4'b0001 first at cycle 2, low from cycle 18; at cycle 32, `idx`=1.
- WRITE 0x5 to digit 2 (frame 11'b00_10_000_0101) -> on slot 2 (cycles 64..95) `seg_data`=5 and `digit_en`=4'b0100 during phases 1..8.
- BRIGHT 0 -> `digit_en` stays 0 for a full 128-cycle scan; BRIGHT 15 -> on-time is 30 of every 32 cycles.
- BLANK 4'b1010 -> `digit_en` never shows bits 1 or 3; digits 0 and 2 are unaffected.
- CLEAR with a WRITE held on `frame_valid` -> `frame_ready` low 4 cycles; all digits 0, `duty`=8; the WRITE is accepted on cycle 5 after the CLEAR accept. Repeat with `rst_n` pulsed during cycle 2 of CLEAR -> reset values, `frame_ready`=1 next cycle.
- With `DISP_FRAME_CHECK_EN`: WRITE with [6:4]=3'b001 -> digit unchanged, `frame_err`=1 and still 1 after later valid frames; without the macro, the same frame writes the digit and `frame_err`=0.
